// File: rtl/wishbone_b3_slave_pkg.sv
// Shared types and helpers for the Wishbone B3 classic slave memory.
// Contains no logic; it is imported by the top-level and the RAM.
package wishbone_b3_slave_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      RSP_ACK = 2'd0,
      RSP_ERR = 2'd1,
      RSP_RTY = 2'd2
   } rsp_e;

   // Number of byte-offset address bits dropped to form the word index.
   function automatic int adr_shift(input int sel_w);
      int s;
      s = 0;
      while ((1 << s) < sel_w) s++;
      return s;
   endfunction

endpackage

// File: rtl/wishbone_b3_slave_ram.sv
// Single-port word RAM with byte write enables, a tag write enable and a registered read.
// One-cycle read; no reset, so contents survive a bus reset.
module wishbone_b3_slave_ram #(
   parameter int  DAT_W = 64,
   parameter int  TAG_W = 1,
   parameter int  DEPTH = 1024,
   localparam int SEL_W = DAT_W / 8,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] addr,
   input  logic [SEL_W-1:0] be,
   input  logic             tag_we,
   input  logic [DAT_W-1:0] wdat,
   input  logic [TAG_W-1:0] wtag,
   input  logic             re,
   output logic [DAT_W-1:0] rdat_q,
   output logic [TAG_W-1:0] rtag_q
);

   logic [DAT_W-1:0] dmem [DEPTH];
   logic [TAG_W-1:0] tmem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < SEL_W; b++) begin
         if (be[b]) dmem[addr][b*8 +: 8] <= wdat[b*8 +: 8];
      end
      if (tag_we) tmem[addr] <= wtag;
      if (re) begin
         rdat_q <= dmem[addr];
         rtag_q <= tmem[addr];
      end
   end

endmodule

// File: rtl/wishbone_b3_slave_mem.sv
// Wishbone B3 classic slave over a byte-enabled tagged memory: ack/err/rty after WAIT_STATES+1 cycles.
// No backpressure beyond the protocol itself; dropping cyc/stb before the response aborts silently.
module wishbone_b3_slave_mem
   import wishbone_b3_slave_pkg::*;
#(
   parameter int  DAT_W       = 64,
   parameter int  ADR_W       = 32,
   parameter int  TAG_W       = 1,
   parameter int  DEPTH       = 1024,
   parameter int  WAIT_STATES = 0,
   localparam int SEL_W       = DAT_W / 8
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             cyc_i,
   input  logic             stb_i,
   input  logic             we_i,
   input  logic [ADR_W-1:0] adr_i,
   input  logic [SEL_W-1:0] sel_i,
   input  logic [DAT_W-1:0] dat_i,
   input  logic [TAG_W-1:0] tgd_i,
   input  logic             busy_i,
   output logic             ack_o,
   output logic             err_o,
   output logic             rty_o,
   output logic [DAT_W-1:0] dat_o,
   output logic [TAG_W-1:0] tgd_o
);

   localparam int               SHIFT   = adr_shift(SEL_W);
   localparam int               IDX_W   = $clog2(DEPTH);
   localparam logic [ADR_W-1:0] DEPTH_A = ADR_W'(DEPTH);
   localparam logic [3:0]       WS_LOAD = 4'(WAIT_STATES - 1);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             ack_q, ack_d, err_q, err_d, rty_q, rty_d;
   logic             rd_vld_q, rd_vld_d;
   logic             req, enter_resp, oor;
   logic [ADR_W-1:0] word_idx;
   rsp_e             rsp;
   logic [SEL_W-1:0] ram_be;
   logic             ram_tag_we, ram_re;
   logic [DAT_W-1:0] ram_dat;
   logic [TAG_W-1:0] ram_tag;

   assign req      = cyc_i & stb_i;
   assign word_idx = adr_i >> SHIFT;
   // Full-width compare so addresses past DEPTH never alias onto low words.
   assign oor      = (word_idx >= DEPTH_A);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (WAIT_STATES == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WS_LOAD;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rsp = RSP_ACK;
      if (oor)         rsp = RSP_ERR;
      else if (busy_i) rsp = RSP_RTY;
      ack_d      = enter_resp && (rsp == RSP_ACK);
      err_d      = enter_resp && (rsp == RSP_ERR);
      rty_d      = enter_resp && (rsp == RSP_RTY);
      rd_vld_d   = enter_resp ? (ack_d && !we_i) : rd_vld_q;
      // Reset must win over a commit landing on the same edge.
      ram_be     = (ack_d && we_i && !rst_i) ? sel_i : '0;
      ram_tag_we = |ram_be;
      ram_re     = ack_d && !we_i && !rst_i;
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rty_q    <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rty_q    <= rty_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   wishbone_b3_slave_ram #(
      .DAT_W (DAT_W),
      .TAG_W (TAG_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk    (clk),
      .addr   (word_idx[IDX_W-1:0]),
      .be     (ram_be),
      .tag_we (ram_tag_we),
      .wdat   (dat_i),
      .wtag   (tgd_i),
      .re     (ram_re),
      .rdat_q (ram_dat),
      .rtag_q (ram_tag)
   );

   assign ack_o = ack_q;
   assign err_o = err_q;
   assign rty_o = rty_q;
   // Error, retry and write responses present zero read data.
   assign dat_o = rd_vld_q ? ram_dat : '0;
   assign tgd_o = rd_vld_q ? ram_tag : '0;

   always @(posedge clk) begin
      if (!rst_i) begin
         assert ($onehot0({ack_o, err_o, rty_o}));
         assert (!(ack_o || err_o || rty_o) || (state_q == RESP));
      end
   end

endmodule
